// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with a frame-aligned double-buffered
// update handshake and optional leading-zero suppression.

module seg_scan_digit (
  input  logic [3:0] code,
  input  logic       sup,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (!sup) begin
      case (code)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIV = 100000,
  parameter int GAP = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iData,
  input  logic        iLzs,
  output logic        oAck,
  output logic        oBusy,
  output logic [7:0]  oAn,
  output logic [6:0]  oSeg
);
  localparam int NUM_DIG = 8;
  localparam int NW      = 4;
  localparam int CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [CW-1:0] GAPC = CW'(GAP);

  logic [CW-1:0]                    cnt;
  logic [2:0]                       idx;
  logic [NUM_DIG*NW-1:0]            live, shadow;
  logic [NUM_DIG-1:0]               sup;
  logic [NUM_DIG-1:0][6:0]          segs;
  logic                             accept, frameEnd, blank;

  assign accept   = iReq && !oBusy && !oAck;
  assign frameEnd = (idx == 3'd7) && (cnt == CMAX);
  assign blank    = rst || (cnt < GAPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      live   <= '1;
      shadow <= '1;
      oBusy  <= 1'b0;
      oAck   <= 1'b0;
    end else begin
      oAck <= accept;
      if (cnt == CMAX) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // accept needs !oBusy, so it never collides with the frame-boundary transfer
      if (accept) begin
        shadow <= iData;
        oBusy  <= 1'b1;
      end else if (frameEnd && oBusy) begin
        live  <= shadow;
        oBusy <= 1'b0;
      end
    end
  end

  // Digit k blanks under suppression when nibbles k..7 are all zero; digit 0 never does.
  for (genvar k = 0; k < NUM_DIG; k++) begin : gDig
    if (k == 0) begin : gLsd
      assign sup[k] = 1'b0;
    end else begin : gUpper
      assign sup[k] = iLzs && (live[NUM_DIG*NW-1:NW*k] == '0);
    end
    seg_scan_digit uDig (
      .code (live[NW*k +: NW]),
      .sup  (sup[k]),
      .seg  (segs[k])
    );
  end

  assign oAn  = blank ? 8'hFF : ~(8'b1 << idx);
  assign oSeg = blank ? 7'h7F : segs[idx];

endmodule
